// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and word helpers for hamming_word_gen.
//   W     : word width
//   KW    : width of the requested weight k
//   IDX_W : width of the word index (holds C(W, W/2) - 1 without wrapping)
package hamming_pkg;

  localparam int W     = 16;
  localparam int KW    = $clog2(W + 1);
  localparam int IDX_W = 14;

  // state | meaning
  // IDLE  | waiting for start; x/idx keep the last run's final values
  // EMIT  | presenting x with out_valid=1 until the last word is accepted
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Smallest word of weight k: k ones packed at the LSB end.
  function automatic logic [W-1:0] first_word(input logic [KW-1:0] k);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = (i < int'(k));
    return w;
  endfunction

  // Largest word of weight k: k ones packed at the MSB end.
  function automatic logic [W-1:0] last_word(input logic [KW-1:0] k);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = (i >= W - int'(k));
    return w;
  endfunction

endpackage

// File: rtl/hamming_word_gen_gosper.sv
// Combinational next-word step: returns the next larger word with the same
// popcount as x (Gosper's hack, no divider).
//   x   : current word
//   nxt : next word of equal weight (meaningless when x is the last word)
module gosper_next
  import hamming_pkg::*;
(
  input  logic [W-1:0] x,
  output logic [W-1:0] nxt
);

  logic [W:0]   xe;
  logic [W:0]   c;
  logic [W:0]   r;
  logic [W-1:0] t;
  logic [4:0]   ctz;
  logic [5:0]   shamt;

  // Carry into bit W only happens for the last word, which never advances.
  assign xe = {1'b0, x};
  assign c  = xe & (~xe + 1'b1);
  assign r  = xe + c;

  // c is one-hot, so the lowest-set-bit search yields ctz(c) directly.
  always_comb begin
    ctz = '0;
    for (int i = W; i >= 0; i--) begin
      if (c[i]) ctz = 5'(i);
    end
  end

  assign shamt = {1'b0, ctz} + 6'd2;
  // Shift by at least 2 keeps the top bit clear, so W bits hold the result.
  assign t     = W'((r ^ xe) >> shamt);
  assign nxt   = r[W-1:0] | t;

endmodule

// File: rtl/hamming_word_gen.sv
// Streams every W-bit word of Hamming weight k in ascending order over a
// valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   start, k             : request a run of weight k (sampled only in IDLE)
//   busy                 : run in progress
//   out_valid, out_ready : handshake for x/idx/last
//   x, idx, last         : current word, its 0-based index, final-word flag
//   done                 : one-cycle pulse after the final word is accepted
//   err                  : one-cycle pulse when start arrives with k > W
module hamming_word_gen
  import hamming_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    k,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             done,
  output logic             err
);

  state_t             state_q, state_d;
  logic [W-1:0]       x_q, x_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [KW-1:0]      k_q, k_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [W-1:0]       nxt;
  logic               last_w;

  gosper_next u_gosper (
    .x   (x_q),
    .nxt (nxt)
  );

  assign last_w = (state_q == EMIT) && (x_q == last_word(k_q));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k > KW'(W)) begin
            err_d = 1'b1;
          end else begin
            state_d = EMIT;
            x_d     = first_word(k);
            idx_d   = '0;
            k_d     = k;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            x_d   = nxt;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign x         = x_q;
  assign idx       = idx_q;
  assign last      = last_w;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/hamming_word_gen.md
Name: hamming_word_gen

Overview:
- Sequential generator for the inverse of the 16-bit popcount block: given a requested Hamming weight k, it streams every 16-bit word with exactly k ones.
- Words come out in strictly ascending numeric order over a valid/ready handshake.
- Used as a stimulus/enumeration source and as the producer side feeding the popcount checker.

Parameters:
W, 16, word width in bits
KW, 5, width of k input; $clog2(W+1)
IDX_W, 14, width of word index; 2**IDX_W > C(W, W/2) (12870 for W=16)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a new enumeration; sampled only in IDLE
k  input  KW  requested weight, sampled with start
busy  output  1  high while an enumeration is in progress
out_valid  output  1  x/idx/last are valid
out_ready  input  1  consumer accepts the current word
x  output  W  current word, popcount(x)==k
idx  output  IDX_W  0-based index of x within the enumeration
last  output  1  x is the final word (k ones packed at MSB end)
done  output  1  one-cycle pulse after the last word is accepted
err  output  1  one-cycle pulse: start with k>W

Behaviour:
- One clock domain. rst_n is asynchronous and active-low.
- Reset, asynchronous on negedge rst_n, regardless of state: state=IDLE; x=0, idx=0, busy=0, out_valid=0, last=0, done=0, err=0.
- States: IDLE, EMIT.
- IDLE, start=1 and k<=W:
  - Next cycle: state=EMIT, x=(1<<k)-1, idx=0, busy=1, out_valid=1.
  - Latency start->first valid is 1 cycle.
- IDLE, start=1 and k>W: err=1 for 1 cycle; stay IDLE; no out_valid.
- start while busy is ignored; k is not resampled.
- EMIT:
  - out_valid=1 continuously.
  - last is combinational: x == ((1<<k)-1) << (W-k), with k held in a register. For k=0 the word is 0; for k=W it is all ones.
- Handshake rules:
  - Transfer occurs when out_valid && out_ready.
  - With no transfer, x, idx and last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Transfer with last=0:
  - x <= gosper_next(x); idx <= idx+1.
  - Throughput is 1 word/cycle while out_ready is held high.
- Transfer with last=1: next cycle state=IDLE, out_valid=0, busy=0, done=1 for 1 cycle. x and idx keep their final values.
- A new start is accepted in the cycle done is high, since state is already IDLE.
- Next-word arithmetic (Gosper, no divider), all computed at W+1 bits:
  - c = x & -x
  - r = x + c
  - t = (r ^ x) >> (2 + ctz(c))
  - next = (r | t)[W-1:0]
  - ctz comes from a priority encoder.
  - The carry-out of r occurs only when x is the last word; it is never used because last gates the update.
- Degenerate weights: k=0 and k=W each produce exactly one word with last=1 and idx=0.
- Word count per run is C(W,k); idx never wraps for any legal k.

Decomposition:
- Package hamming_pkg:
  - W default constant
  - state enum {IDLE, EMIT}
  - function first_word(k)
  - function last_word(k)
- Sub-module gosper_next: purely combinational, input x[W-1:0], output nxt[W-1:0]. Contains the lowbit isolation, the adder and the ctz-based shift.
- The top level holds the FSM, the registers and the handshake.

Test Plan:
- start, k=2, out_ready=1 -> x=0x0003,0x0005,0x0006,0x0009,0x000A,...; final word 0xC000 with idx=119, last=1; done pulses the next cycle.
- k=8, out_ready=1 -> 12870 words. Each word checked with hamming16: count==8. Words strictly increasing. Final word 0xFF00, idx=12869. No gaps: bench compares against an exhaustive 0..65535 scan.
- k=0 -> one word 0x0000, last=1, idx=0. k=16 -> one word 0xFFFF, last=1, idx=0. done pulses after each.
- k=3, out_ready toggled pseudo-randomly -> x/idx/last stable whenever out_ready=0. Sequence is identical to the out_ready=1 run (first 0x0007, last 0xE000 at idx=559).
- start with k=17 -> err=1 for one cycle; busy, out_valid, done stay 0. start again while busy with k=4 -> ignored, run completes with original k.
- Reset asserted mid-run (k=5, idx≈100) -> outputs 0 immediately, without waiting for a clock edge. After release, start k=1 -> 0x0001..0x8000, idx 0..15.
